// File: rtl/down_count_checker.sv
// Monitors a free-running down counter. Each qualified sample must be the previous
// sample minus one (mod 2^WIDTH); reports lock, step errors and wrap events.
//
// state  | meaning
// SEARCH | counting consecutive good steps toward LOCK_CNT; errors are not reported
// LOCKED | sequence verified; a bad step raises err_pulse and drops back to SEARCH
module down_count_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] count_in,
    input  logic             count_vld,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count
);

    typedef enum logic {SEARCH, LOCKED} state_t;

    localparam logic [3:0]       LOCK_V  = 4'(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic             have_prev;
    logic [3:0]       run;

    logic [WIDTH-1:0] prev_dec;
    logic [3:0]       run_inc;
    logic             step_ok;
    logic             eval;
    logic             err_ev;
    logic             wrap_ev;

    // Only the second and later valid samples after reset carry a step to judge.
    always_comb begin
        prev_dec = prev - 1'b1;
        run_inc  = run + 4'd1;
        step_ok  = (count_in == prev_dec);
        eval     = count_vld && have_prev;
        err_ev   = eval && (state == LOCKED) && !step_ok;
        wrap_ev  = eval && (state == LOCKED) && step_ok && (prev == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEARCH;
            prev       <= '0;
            have_prev  <= 1'b0;
            run        <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            err_pulse  <= err_ev;
            wrap_pulse <= wrap_ev;

            // Clear wins over a same-edge increment; the pulses still fire.
            if (clr_cnt) begin
                err_count  <= '0;
                wrap_count <= '0;
            end else begin
                if (err_ev && (err_count != CNT_MAX))
                    err_count <= err_count + 1'b1;
                if (wrap_ev && (wrap_count != CNT_MAX))
                    wrap_count <= wrap_count + 1'b1;
            end

            if (count_vld) begin
                prev      <= count_in;
                have_prev <= 1'b1;
            end

            if (eval) begin
                case (state)
                    SEARCH: begin
                        if (step_ok) begin
                            if (run_inc == LOCK_V) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                run    <= '0;
                            end else begin
                                run <= run_inc;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!step_ok) begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                            run    <= '0;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: doc/down_count_checker.md
Name: down_count_checker

Overview:
- Downstream monitor for the free-running 4-bit down counter.
- Samples the counter value on a qualified clock edge and checks that each sample is exactly the previous sample minus one, modulo 2^WIDTH.
- Reports lock status, step errors and wrap events, and keeps saturating event counters for debug and status readout.
- Sits directly on the counter's count output, in the same clock domain.

Parameters:
- WIDTH, 4, width of the monitored count value.
- LOCK_CNT, 3, number of consecutive good decrement steps required to assert locked; legal range 1..15.
- CNT_W, 8, width of the saturating err_count and wrap_count status counters.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset; deassertion synchronous to clk outside this block.
- count_in  input  WIDTH  counter value under test.
- count_vld  input  1  sample qualifier; count_in is sampled only on edges where this is 1.
- clr_cnt  input  1  synchronous clear of err_count and wrap_count.
- locked  output  1  sequence verified; registered.
- err_pulse  output  1  one-cycle pulse on a bad step while locked.
- wrap_pulse  output  1  one-cycle pulse on a good 0 -> all-ones step while locked.
- err_count  output  CNT_W  saturating number of err_pulse events.
- wrap_count  output  CNT_W  saturating number of wrap_pulse events.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, the prev register 0, have_prev 0, run counter 0, FSM in SEARCH. Reset asserted mid-operation aborts immediately; there is no retained state.
- Internal state: prev (WIDTH), have_prev (1), run (4 bits), FSM {SEARCH, LOCKED}.
- Sampling: on each edge with count_vld=1, prev <= count_in and have_prev <= 1.
  - The first sample after reset only loads prev; no step is evaluated.
  - Edges with count_vld=0 change nothing except clr_cnt effects; err_pulse and wrap_pulse go to 0.
- Step check: step_ok = (count_in == prev - 1), computed modulo 2^WIDTH. So prev=0 expects all-ones (wrap).
- Latency: all outputs are registered. Results for a sample captured at edge k are visible after edge k, the same edge that captures it.
- SEARCH state:
  - step_ok: run <= run+1. If run+1 == LOCK_CNT: go to LOCKED, locked <= 1, run <= 0.
  - Bad step: run <= 0. No err_pulse and no err_count increment (no error while unlocked).
  - No wrap_pulse in SEARCH.
- LOCKED state:
  - step_ok: stay in LOCKED. If prev==0, then wrap_pulse <= 1 and wrap_count increments.
  - Bad step: err_pulse <= 1, err_count increments, locked <= 0, state <= SEARCH, run <= 0. The bad sample still loads prev and becomes the new reference.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clr_cnt=1 forces both counters to 0 on that edge and has priority over a simultaneous increment (result reads 0).
  - The pulses themselves still fire.
  - clr_cnt does not affect locked, FSM, prev or run.
- err_pulse and wrap_pulse are mutually exclusive by construction. Each is high for exactly one cycle per event, even with back-to-back valid samples.

Test Plan:
- Reset: assert rst_n=0 mid-stream while locked with err_count=2 -> all outputs 0 immediately, without waiting for a clock edge. After release, the first valid sample produces no pulse.
- Lock acquisition: valid every cycle with F,E,D,C -> locked=0 after F,E,D and locked=1 after the edge capturing C; no err_pulse.
- Wrap: continue locked through 2,1,0,F -> wrap_pulse high exactly one cycle after the edge capturing F; wrap_count=1; locked stays 1.
- Error and relock:
  - Locked at 9, then inject 5 instead of 8 -> err_pulse for one cycle, err_count=1, locked=0.
  - Then feed 4,3,2 -> locked=1 after 2; err_count stays 1.
- Qualifier gaps: locked at 7, count_vld=0 for 3 cycles with count_in toggling randomly, then valid 6 -> no err_pulse; locked stays 1.
- Saturation and clear:
  - With CNT_W=8, force 300 errors (lock, break, relock) -> err_count=255 and holds.
  - clr_cnt=1 on the same edge as an err_pulse -> err_pulse=1, err_count=0 after that edge.
